// File: rtl/mv_select.sv
// Best-match selector: aligns the controller schedule with returning SADs, tracks the
// minimum over one search window and presents the winning motion vector via valid/ready.
module mv_select #(
  parameter int SAD_WIDTH = 16,
  parameter int ROWS      = 15,
  parameter int PIPE_LAT  = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 en_init,
  input  logic                 en_pe,
  input  logic [3:0]           ctr_word,
  input  logic [SAD_WIDTH-1:0] sad_in,
  input  logic                 mv_ready,
  output logic                 mv_valid,
  output logic [SAD_WIDTH-1:0] best_sad,
  output logic [4:0]           mv_x,
  output logic [4:0]           mv_y,
  output logic                 busy,
  output logic                 overrun
);

  localparam logic [3:0] ROW_LAST = 4'(ROWS - 1);
  localparam logic [4:0] ROW_CTR  = 5'((ROWS - 1) / 2);
  localparam logic [3:0] COL_LAST = 4'd14;
  localparam logic [4:0] COL_CTR  = 5'd7;

  typedef enum logic [0:0] {
    IDLE   = 1'b0,
    SEARCH = 1'b1
  } state_t;

  state_t state_r, state_s;

  logic                 d_en_s;
  logic [3:0]           d_word_s;
  logic [3:0]           row_r;
  logic [SAD_WIDTH-1:0] best_r;
  logic [3:0]           best_col_r;
  logic [3:0]           best_row_r;

  logic                 accept_s;
  logic [3:0]           col_s;
  logic                 better_s;
  logic                 last_col_s;
  logic                 done_s;
  logic [SAD_WIDTH-1:0] fin_sad_s;
  logic [3:0]           fin_col_s;
  logic [3:0]           fin_row_s;

  generate
    if (PIPE_LAT == 0) begin : g_direct
      assign d_en_s   = en_pe;
      assign d_word_s = ctr_word;
    end else begin : g_delay
      logic [PIPE_LAT-1:0] en_sr_r;
      logic [3:0]          word_sr_r [PIPE_LAT];

      // Delay line carrying {en_pe, ctr_word} so it lines up with sad_in
      always_ff @(posedge clk) begin
        if (!rst_n || en_init) begin
          en_sr_r <= '0;
          for (int i = 0; i < PIPE_LAT; i++) begin
            word_sr_r[i] <= 4'd0;
          end
        end else begin
          en_sr_r[0]   <= en_pe;
          word_sr_r[0] <= ctr_word;
          for (int i = 1; i < PIPE_LAT; i++) begin
            en_sr_r[i]   <= en_sr_r[i-1];
            word_sr_r[i] <= word_sr_r[i-1];
          end
        end
      end

      assign d_en_s   = en_sr_r[PIPE_LAT-1];
      assign d_word_s = word_sr_r[PIPE_LAT-1];
    end
  endgenerate

  // Candidate qualification and the final compare folded into the completing cycle
  always_comb begin
    accept_s   = (state_r == SEARCH) && !en_init && d_en_s && (d_word_s != 4'd0);
    col_s      = d_word_s - 4'd1;
    better_s   = accept_s && (sad_in < best_r);
    last_col_s = accept_s && (col_s == COL_LAST);
    done_s     = last_col_s && (row_r == ROW_LAST);
    if (better_s) begin
      fin_sad_s = sad_in;
      fin_col_s = col_s;
      fin_row_s = row_r;
    end else begin
      fin_sad_s = best_r;
      fin_col_s = best_col_r;
      fin_row_s = best_row_r;
    end
  end

  // Next-state logic
  always_comb begin
    state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!en_init) begin
          state_s = SEARCH;
        end else begin
          state_s = IDLE;
        end
      end
      SEARCH: begin
        if (en_init || done_s) begin
          state_s = IDLE;
        end else begin
          state_s = SEARCH;
        end
      end
      default: state_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Row counter and running best; IDLE holds the fresh-search values
  always_ff @(posedge clk) begin
    if (!rst_n || en_init || (state_r == IDLE)) begin
      row_r      <= 4'd0;
      best_r     <= '1;
      best_col_r <= 4'd0;
      best_row_r <= 4'd0;
    end else if (accept_s) begin
      if (better_s) begin
        best_r     <= sad_in;
        best_col_r <= col_s;
        best_row_r <= row_r;
      end
      if (done_s) begin
        row_r <= 4'd0;
      end else if (last_col_s) begin
        row_r <= row_r + 4'd1;
      end
    end
  end

  // Result register with valid/ready handshake and sticky overrun
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mv_valid <= 1'b0;
      best_sad <= '0;
      mv_x     <= 5'd0;
      mv_y     <= 5'd0;
      overrun  <= 1'b0;
    end else begin
      if (done_s) begin
        best_sad <= fin_sad_s;
        mv_x     <= {1'b0, fin_col_s} - COL_CTR;
        mv_y     <= {1'b0, fin_row_s} - ROW_CTR;
        mv_valid <= 1'b1;
      end else if (mv_valid && mv_ready) begin
        mv_valid <= 1'b0;
      end
      if (en_init) begin
        overrun <= 1'b0;
      end else if (done_s && mv_valid && !mv_ready) begin
        overrun <= 1'b1;
      end
    end
  end

  assign busy = (state_r == SEARCH);

endmodule

// File: tb/tb_mv_select.sv
// Scoreboard bench for mv_select: two instances (PIPE_LAT 2 and 0) share one schedule;
// expected results come from a row-major minimum search over the SAD map.
module tb_mv_select;

  logic        clk = 1'b0;
  logic        rst_n, en_init, en_pe, mv_ready;
  logic [3:0]  ctr_word;
  logic [15:0] sad_a, sad_b;
  logic        va, vb, busya, busyb, ova, ovb;
  logic [15:0] bsa, bsb;
  logic [4:0]  xa, ya, xb, yb;

  int errors = 0;
  int checks = 0;

  typedef struct packed {
    logic [15:0] sad;
    logic [4:0]  x;
    logic [4:0]  y;
  } res_t;

  res_t        exp_a[$];
  res_t        exp_b[$];
  logic [15:0] sad_map [15][15];
  logic [15:0] h0, h1;
  bit          rnd_ready = 1'b0;

  always #5 clk = ~clk;

  mv_select #(.SAD_WIDTH(16), .ROWS(15), .PIPE_LAT(2)) dut_a (
    .clk(clk), .rst_n(rst_n), .en_init(en_init), .en_pe(en_pe), .ctr_word(ctr_word),
    .sad_in(sad_a), .mv_ready(mv_ready), .mv_valid(va), .best_sad(bsa), .mv_x(xa),
    .mv_y(ya), .busy(busya), .overrun(ova)
  );

  mv_select #(.SAD_WIDTH(16), .ROWS(15), .PIPE_LAT(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .en_init(en_init), .en_pe(en_pe), .ctr_word(ctr_word),
    .sad_in(sad_b), .mv_ready(mv_ready), .mv_valid(vb), .best_sad(bsb), .mv_x(xb),
    .mv_y(yb), .busy(busyb), .overrun(ovb)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, req);
    end
  endtask

  // Monitors: every transfer must match the oldest outstanding expectation
  always @(negedge clk) begin
    res_t e;
    if (rst_n && mv_ready && va) begin
      if (exp_a.size() == 0) begin
        check("a_unexpected_result", {bsa, xa, ya}, 64'd0);
      end else begin
        e = exp_a.pop_front();
        check("a_result", {bsa, xa, ya}, e);
      end
    end
  end

  always @(negedge clk) begin
    res_t e;
    if (rst_n && mv_ready && vb) begin
      if (exp_b.size() == 0) begin
        check("b_unexpected_result", {bsb, xb, yb}, 64'd0);
      end else begin
        e = exp_b.pop_front();
        check("b_result", {bsb, xb, yb}, e);
      end
    end
  end

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic fill(input int lo, input int hi);
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        sad_map[r][c] = 16'($urandom_range(hi, lo));
  endtask

  // Reference: first strict minimum in row-major order
  task automatic push_expected();
    int          br = 0;
    int          bc = 0;
    logic [15:0] bv = sad_map[0][0];
    res_t        e;
    for (int r = 0; r < 15; r++)
      for (int c = 0; c < 15; c++)
        if (sad_map[r][c] < bv) begin
          bv = sad_map[r][c];
          br = r;
          bc = c;
        end
    e.sad = bv;
    e.x   = 5'(bc - 7);
    e.y   = 5'(br - 7);
    exp_a.push_back(e);
    exp_b.push_back(e);
  endtask

  task automatic start();
    en_init  = 1'b1;
    en_pe    = 1'($urandom);
    ctr_word = 4'($urandom);
    cycle();
    en_init  = 1'b0;
    en_pe    = 1'b0;
    ctr_word = 4'd0;
    cycle();
    check("a_busy_after_init", busya, 64'd1);
    check("b_busy_after_init", busyb, 64'd1);
  endtask

  // 24-cycle row schedule: 15 candidates then 9 junk cycles
  task automatic run_rows(input int nrows, input int last_len, input bit tcheck);
    logic [15:0] cur;
    for (int r = 0; r < nrows; r++) begin
      for (int c = 0; c < 24; c++) begin
        if (r == nrows - 1 && c >= last_len) break;
        if (c < 15) begin
          en_pe    = 1'b1;
          ctr_word = 4'(c + 1);
          cur      = sad_map[r][c];
        end else begin
          if ($urandom_range(1, 0) == 1) begin
            en_pe    = 1'b1;
            ctr_word = 4'd0;
          end else begin
            en_pe    = 1'b0;
            ctr_word = 4'($urandom_range(15, 1));
          end
          cur = 16'($urandom);
        end
        sad_b = cur;
        sad_a = h1;
        if (rnd_ready) mv_ready = 1'($urandom);
        cycle();
        h1 = h0;
        h0 = cur;
        if (tcheck && r == 14) begin
          if (c == 14) begin
            check("b_latency_valid", vb, 64'd1);
            check("b_busy_done", busyb, 64'd0);
            check("a_not_early", va, 64'd0);
          end
          if (c == 15) check("a_not_early2", va, 64'd0);
          if (c == 16) begin
            check("a_latency_valid", va, 64'd1);
            check("a_busy_done", busya, 64'd0);
          end
        end
      end
    end
    en_pe    = 1'b0;
    ctr_word = 4'd0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0;
    h0 = 16'd0;
    h1 = 16'd0;
    for (int i = 0; i < 3; i++) begin
      en_init  = 1'($urandom);
      en_pe    = 1'($urandom);
      ctr_word = 4'($urandom);
      sad_a    = 16'($urandom);
      sad_b    = 16'($urandom);
      mv_ready = 1'($urandom);
      cycle();
      check("a_reset", {va, bsa, xa, ya, busya, ova}, 64'd0);
      check("b_reset", {vb, bsb, xb, yb, busyb, ovb}, 64'd0);
    end
    rst_n    = 1'b1;
    mv_ready = 1'b1;
    en_init  = 1'b1;

    // Single minimum with latency checks
    fill(1000, 1000);
    sad_map[3][10] = 16'd17;
    push_expected();
    start();
    run_rows(15, 24, 1'b1);

    // Tie: earliest wins
    fill(900, 900);
    sad_map[0][0]   = 16'd5;
    sad_map[14][14] = 16'd5;
    push_expected();
    start();
    run_rows(15, 24, 1'b0);

    // Abort mid-row 6, then a clean search
    fill(0, 5000);
    start();
    run_rows(7, 8, 1'b0);
    fill(3, 5000);
    sad_map[7][7] = 16'd2;
    push_expected();
    start();
    run_rows(15, 24, 1'b0);

    // Minimum at the last row, first column
    fill(10, 60000);
    sad_map[14][0] = 16'd9;
    push_expected();
    start();
    run_rows(15, 24, 1'b0);

    // All-ones map: no update, position stays (0,0)
    fill(65535, 65535);
    push_expected();
    start();
    run_rows(15, 24, 1'b0);

    // Backpressure across two searches
    mv_ready = 1'b0;
    fill(100, 5000);
    sad_map[$urandom_range(14, 0)][$urandom_range(14, 0)] = 16'd40;
    start();
    run_rows(15, 24, 1'b0);
    check("a_no_overrun_yet", ova, 64'd0);
    fill(100, 5000);
    sad_map[$urandom_range(14, 0)][$urandom_range(14, 0)] = 16'd30;
    push_expected();
    start();
    run_rows(15, 24, 1'b0);
    check("a_overrun_set", ova, 64'd1);
    check("b_overrun_set", ovb, 64'd1);
    check("a_valid_held", va, 64'd1);
    mv_ready = 1'b1;
    cycle();
    mv_ready = 1'b0;
    check("a_valid_cleared", va, 64'd0);
    check("b_valid_cleared", vb, 64'd0);
    start();
    check("a_overrun_cleared", ova, 64'd0);
    check("b_overrun_cleared", ovb, 64'd0);
    mv_ready = 1'b1;

    // Random maps with ties likely and random backpressure
    rnd_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      fill(0, 200);
      push_expected();
      start();
      run_rows(15, 24, 1'b0);
    end
    rnd_ready = 1'b0;
    mv_ready  = 1'b1;
    for (int i = 0; i < 6; i++) cycle();
    check("a_queue_drained", exp_a.size(), 64'd0);
    check("b_queue_drained", exp_b.size(), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mv_select.md
# mv_select

Best-match selector at the output end of the full-search block-matching datapath. It consumes the schedule that the search controller drives: `en_init`, `en_pe`, and the 4-bit `ctr_word`. It pairs that schedule with the SAD values coming back from the PE array, tracks the minimum SAD over one complete search window, and presents the winning motion vector through a valid/ready output register. It sits between the PE array SAD output and the downstream motion-vector consumer.

## Interface
- `SAD_WIDTH`, 16: width of the SAD values and of `best_sad`.
- `ROWS`, 15: candidate rows per search window; must be odd, 3..15. Columns per row are fixed at 15 (`ctr_word` 1..15).
- `PIPE_LAT`, 2: cycles from a sampled `en_pe`/`ctr_word` to the matching `sad_in`; range 0..7.
- `clk` in 1: clock. All logic is on the rising edge.
- `rst_n` in 1: reset, synchronous, active-low.
- `en_init` in 1: search restart/initialisation. While high, the block is held cleared.
- `en_pe` in 1: PE-enable from the controller; qualifies `ctr_word`.
- `ctr_word` in 4: candidate column code from the controller. 1..15 maps to column 0..14; 0 is ignored.
- `sad_in` in `SAD_WIDTH`: SAD of the candidate issued `PIPE_LAT` cycles earlier; unsigned.
- `mv_ready` in 1: downstream accepts the result.
- `mv_valid` out 1: result register holds an unconsumed result.
- `best_sad` out `SAD_WIDTH`: minimum SAD of the last completed search.
- `mv_x` out 5: signed column offset, equal to col − (15−1)/2, range −7..+7.
- `mv_y` out 5: signed row offset, equal to row − (`ROWS`−1)/2.
- `busy` out 1: high while in SEARCH.
- `overrun` out 1: sticky; an unconsumed result was overwritten.

## Operation
- **Alignment**
  - A `PIPE_LAT`-deep shift register carries {`en_pe`, `ctr_word`}.
  - Its tail gives `d_en` and `d_word`, aligned to `sad_in`.
  - With `PIPE_LAT` = 0 the inputs are used directly.
- **Accepted candidate:** `d_en` = 1 and `d_word` ≠ 0, in state SEARCH. Column = `d_word` − 1.
- **States**
  - IDLE → SEARCH: first cycle with `en_init` = 0.
  - SEARCH → SEARCH, row += 1: candidate accepted with column 14 and row < `ROWS`−1.
  - SEARCH → IDLE: candidate accepted with column 14 and row = `ROWS`−1. This completes the search.
  - Any state → IDLE: `en_init` = 1. This also clears the delay line, row, running best, and `overrun`.
- **Running best**
  - Reset to all-ones with position (0,0) on entering SEARCH.
  - Update on an accepted candidate only if `sad_in` < best (strict). Ties therefore keep the earliest candidate in row-major order.
- **Completion:** the final compare includes the last candidate. The result register loads {min, `mv_x`, `mv_y`} and `mv_valid` is set to 1.
- **Handshake**
  - Transfer occurs at a rising edge with `mv_valid` = 1 and `mv_ready` = 1. `mv_valid` clears next cycle unless a new completion occurs on that edge.
  - Completion while `mv_valid` = 1 and `mv_ready` = 0: the register is overwritten, `mv_valid` stays 1, and `overrun` is set to 1.
  - Completion and transfer on the same edge: the new result loads, `mv_valid` stays 1, and there is no overrun.
- **Robustness**
  - Columns out of order are not checked; the row advances only on column 14.
  - `en_pe` pulses in IDLE are ignored.
- **Arithmetic**
  - Offsets are computed as 5-bit two's complement. The centre for rows is (`ROWS`−1)/2.
  - The comparator is unsigned `SAD_WIDTH` with no saturation.

## Timing
- **Reset** (`rst_n` = 0 at an edge): `mv_valid`=0, `best_sad`=0, `mv_x`=0, `mv_y`=0, `busy`=0, `overrun`=0. State is IDLE, the delay line is cleared, and row = 0.
- **Reset and `en_init` together:** reset has priority over `en_init`. `en_init` does not alter `mv_valid` or the result register.
- **`busy`** rises one cycle after `en_init` falls.
- **Completion latency:** `mv_valid` rises and the outputs update on the edge after the final accepted candidate's cycle.
- **Total latency:** `PIPE_LAT` + 1 cycles after the last (`en_pe`, `ctr_word`=15) sample of row `ROWS`−1.
- **`en_init` mid-search:** aborts with no `mv_valid` pulse. A held earlier result is kept.

## Test plan
- **Reset:** assert `rst_n`=0 with random inputs → all outputs 0, `busy`=0.
- **Single minimum:** `ROWS`=15, `PIPE_LAT`=2, full 24-cycle controller schedule × 15 rows. `sad_in`=1000 except row 3, column 10 = 17. → `mv_valid`=1 exactly 3 cycles after the last `ctr_word`=15; `best_sad`=17, `mv_x`=+3, `mv_y`=−4, `busy`=0.
- **Tie:** SAD 5 at (0,0) and (14,14), 900 elsewhere → `best_sad`=5, `mv_x`=−7, `mv_y`=−7.
- **Abort:** pulse `en_init` at row 6, then run a full search with the minimum 2 at (7,7) → exactly one `mv_valid`, with `mv` (0,0) and `best_sad`=2.
- **Backpressure:**
  - Hold `mv_ready`=0 across two searches (minima 40 then 30) → `best_sad`=30, `overrun`=1.
  - Then `mv_ready`=1 for one cycle → `mv_valid`=0 on the next cycle.
  - Then `en_init` → `overrun`=0.
- **`PIPE_LAT`=0:** with `sad_in` same-cycle and minimum 9 at row 14, column 0 → `mv_x`=−7, `mv_y`=+7, and `mv_valid` one cycle after the final candidate.
